// File: rtl/d_ff_pipe_sel.sv
// d_ff_pipe_sel: mode-selectable retiming register.
//   Short mode (SEL=1): Q follows D through a single flop.
//   Long mode  (SEL=0): Q follows D through a DEPTH-stage delay line plus the
//   output flop. Switching short->long holds Q for DEPTH edges so that the
//   long stream resumes with the sample right after the last short output.
//   Leaving long mode (or aborting the switch) discards in-flight samples and
//   pulses DROP.
//
// Ports:
//   CLK    in   sole clock, rising edge
//   RST_N  in   synchronous active-low reset, applied regardless of EN
//   EN     in   advance enable; all state holds when low
//   SEL    in   requested mode (1 = short, 0 = long)
//   D      in   WIDTH-bit input sample
//   Q      out  WIDTH-bit registered output
//   Q_VLD  out  Q holds a real sample
//   MODE   out  effective mode (1 = short)
//   BUSY   out  short->long switch in progress
//   DROP   out  one-cycle pulse when in-flight samples are discarded
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_SHORT | Q <= D each EN edge
// ST_SW_L  | Q frozen while the delay line fills; hold_cnt counts EN edges
// ST_LONG  | Q <= tail of the delay line each EN edge

module d_ff_pipe_sel #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             SEL,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VLD,
   output logic             MODE,
   output logic             BUSY,
   output logic             DROP
);

   localparam int            CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_TERM = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_SHORT = 2'd0,
      ST_SW_L  = 2'd1,
      ST_LONG  = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0] q_q,        q_d;
   logic             q_vld_q,    q_vld_d;
   logic             drop_q,     drop_d;
   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [WIDTH-1:0] tail;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      q_d        = q_q;
      q_vld_d    = q_vld_q;
      drop_d     = 1'b0;
      stage_d    = stage_q;
      // Sample captured DEPTH EN-edges ago (value before this edge's shift).
      tail       = stage_q[DEPTH-1];

      if (EN) begin
         stage_d[0] = D;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end

         case (state_q)
            ST_SHORT: begin
               if (SEL) begin
                  q_d     = D;
                  q_vld_d = 1'b1;
               end else begin
                  state_d    = ST_SW_L;
                  hold_cnt_d = CW'(1);
               end
            end
            ST_SW_L: begin
               if (SEL) begin
                  q_d        = D;
                  q_vld_d    = 1'b1;
                  drop_d     = 1'b1;
                  state_d    = ST_SHORT;
                  hold_cnt_d = '0;
               end else if (hold_cnt_q == CNT_TERM) begin
                  // DEPTH hold edges done: this edge already emits the tail,
                  // which is the sample captured on the first hold edge.
                  q_d        = tail;
                  q_vld_d    = 1'b1;
                  state_d    = ST_LONG;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + CW'(1);
               end
            end
            ST_LONG: begin
               if (SEL) begin
                  q_d     = D;
                  q_vld_d = 1'b1;
                  drop_d  = 1'b1;
                  state_d = ST_SHORT;
               end else begin
                  q_d     = tail;
                  q_vld_d = 1'b1;
               end
            end
            default: begin
               state_d    = ST_SHORT;
               hold_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_SHORT;
         hold_cnt_q <= '0;
         q_q        <= RST_VAL;
         q_vld_q    <= 1'b0;
         drop_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         q_q        <= q_d;
         q_vld_q    <= q_vld_d;
         drop_q     <= drop_d;
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign Q     = q_q;
   assign Q_VLD = q_vld_q;
   assign DROP  = drop_q;
   assign BUSY  = (state_q == ST_SW_L);
   assign MODE  = (state_q == ST_SHORT);

endmodule

// File: tb/tb_d_ff_pipe_sel.sv
// Bench for d_ff_pipe_sel (WIDTH=8, DEPTH=4, RST_VAL=0): directed vector
// table for the mode sequences, plus a hand-written EN-toggle/reset sequence.

module tb_d_ff_pipe_sel;

   logic       CLK;
   logic       RST_N;
   logic       EN;
   logic       SEL;
   logic [7:0] D;
   logic [7:0] Q;
   logic       Q_VLD;
   logic       MODE;
   logic       BUSY;
   logic       DROP;

   d_ff_pipe_sel #(
      .WIDTH   (8),
      .DEPTH   (4),
      .RST_VAL (8'h00)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (EN),
      .SEL   (SEL),
      .D     (D),
      .Q     (Q),
      .Q_VLD (Q_VLD),
      .MODE  (MODE),
      .BUSY  (BUSY),
      .DROP  (DROP)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      logic       rst_n;
      logic       en;
      logic       sel;
      logic [7:0] d;
      logic [7:0] q;
      logic       vld;
      logic       mode;
      logic       busy;
      logic       drop;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic void add(input string name, input logic rst_n, input logic en,
                               input logic sel, input logic [7:0] d, input logic [7:0] q,
                               input logic vld, input logic mode, input logic busy,
                               input logic drop);
      vec_t v;
      v.name = name; v.rst_n = rst_n; v.en = en; v.sel = sel; v.d = d;
      v.q = q; v.vld = vld; v.mode = mode; v.busy = busy; v.drop = drop;
      vecs.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      RST_N = v.rst_n;
      EN    = v.en;
      SEL   = v.sel;
      D     = v.d;
      @(posedge CLK);
      #1;
      n_vec++;
      if ({Q, Q_VLD, MODE, BUSY, DROP} !== {v.q, v.vld, v.mode, v.busy, v.drop}) begin
         n_err++;
         $display("FAIL %s (d=%0d): got q=%0d vld=%b mode=%b busy=%b drop=%b, want q=%0d vld=%b mode=%b busy=%b drop=%b",
                  v.name, v.d, Q, Q_VLD, MODE, BUSY, DROP, v.q, v.vld, v.mode, v.busy, v.drop);
      end
   endtask

   task automatic step(input string name, input logic rst_n, input logic en,
                       input logic sel, input logic [7:0] d, input logic [7:0] q,
                       input logic vld, input logic mode, input logic busy,
                       input logic drop);
      vec_t v;
      v.name = name; v.rst_n = rst_n; v.en = en; v.sel = sel; v.d = d;
      v.q = q; v.vld = vld; v.mode = mode; v.busy = busy; v.drop = drop;
      apply(v);
   endtask

   initial begin
      RST_N = 1'b0;
      EN    = 1'b1;
      SEL   = 1'b1;
      D     = 8'd0;

      // Short mode from reset: Q = D with one-cycle latency.
      add("rst_short", 0, 1, 1, 8'd0, 8'd0, 0, 1, 0, 0);
      for (int i = 1; i <= 10; i++)
         add("short_follow", 1, 1, 1, 8'(i), 8'(i), 1, 1, 0, 0);

      // Long-mode startup: 4 hold edges with Q invalid, then D(1) after edge 5.
      add("rst_long", 0, 1, 0, 8'd0, 8'd0, 0, 1, 0, 0);
      for (int i = 1; i <= 4; i++)
         add("startup_hold", 1, 1, 0, 8'(i), 8'd0, 0, 0, 1, 0);
      for (int i = 5; i <= 12; i++)
         add("startup_long", 1, 1, 0, 8'(i), 8'(i - 4), 1, 0, 0, 0);

      // Short -> long at Q=20, then long -> short at Q=30, then switch abort.
      add("rst_sw", 0, 1, 1, 8'd0, 8'd0, 0, 1, 0, 0);
      for (int i = 1; i <= 20; i++)
         add("pre_short", 1, 1, 1, 8'(i), 8'(i), 1, 1, 0, 0);
      for (int i = 21; i <= 24; i++)
         add("s2l_hold", 1, 1, 0, 8'(i), 8'd20, 1, 0, 1, 0);
      for (int i = 25; i <= 34; i++)
         add("s2l_long", 1, 1, 0, 8'(i), 8'(i - 4), 1, 0, 0, 0);
      add("l2s_drop", 1, 1, 1, 8'd35, 8'd35, 1, 1, 0, 1);
      add("l2s_after", 1, 1, 1, 8'd36, 8'd36, 1, 1, 0, 0);
      add("abort_hold", 1, 1, 0, 8'd37, 8'd36, 1, 0, 1, 0);
      add("abort_hold", 1, 1, 0, 8'd38, 8'd36, 1, 0, 1, 0);
      add("abort_drop", 1, 1, 1, 8'd39, 8'd39, 1, 1, 0, 1);
      add("abort_after", 1, 1, 1, 8'd40, 8'd40, 1, 1, 0, 0);

      foreach (vecs[k]) apply(vecs[k]);

      // EN toggling during the switch: only EN=1 edges count as hold edges,
      // and SEL is ignored on EN=0 edges.
      step("en_hold1", 1, 1, 0, 8'd41, 8'd40, 1, 0, 1, 0);
      step("en_off",   1, 0, 1, 8'd99, 8'd40, 1, 0, 1, 0);
      step("en_hold2", 1, 1, 0, 8'd42, 8'd40, 1, 0, 1, 0);
      step("en_off",   1, 0, 1, 8'd98, 8'd40, 1, 0, 1, 0);
      step("en_hold3", 1, 1, 0, 8'd43, 8'd40, 1, 0, 1, 0);
      step("en_off",   1, 0, 0, 8'd97, 8'd40, 1, 0, 1, 0);
      step("en_hold4", 1, 1, 0, 8'd44, 8'd40, 1, 0, 1, 0);
      step("en_off",   1, 0, 1, 8'd96, 8'd40, 1, 0, 1, 0);
      step("en_first", 1, 1, 0, 8'd45, 8'd41, 1, 0, 0, 0);

      // Back to short, start a switch, then reset mid-switch (once with EN=0).
      step("mid_l2s",  1, 1, 1, 8'd47, 8'd47, 1, 1, 0, 1);
      step("mid_hold", 1, 1, 0, 8'd48, 8'd47, 1, 0, 1, 0);
      step("mid_hold", 1, 1, 0, 8'd49, 8'd47, 1, 0, 1, 0);
      step("mid_rst",  0, 1, 0, 8'd50, 8'd0,  0, 1, 0, 0);
      step("rst_en0",  0, 0, 0, 8'd51, 8'd0,  0, 1, 0, 0);

      // Restart in long mode: stage registers must have been cleared.
      for (int i = 1; i <= 4; i++)
         step("post_rst_hold", 1, 1, 0, 8'(i), 8'd0, 0, 0, 1, 0);
      for (int i = 5; i <= 7; i++)
         step("post_rst_long", 1, 1, 0, 8'(i), 8'(i - 4), 1, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/d_ff_pipe_sel.md
Name: d_ff_pipe_sel

Overview:
- Parametrised, mode-selectable retiming register: WIDTH-bit data, programmable DEPTH.
- SEL=1 (short mode) gives a single-flop path, 1-cycle latency.
- SEL=0 (long mode) gives a DEPTH+1-cycle delay line.
- Mode changes go through a controlled state machine, so the short-to-long switch neither duplicates nor loses samples. The long-to-short switch flags its discarded samples.
- Sits between data sources and clock-domain-adjacent logic where the retiming depth must be changed at run time.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 4: delay-line stages in long mode (1..16).
- RST_VAL, 0: reset value of Q and all stage registers (WIDTH bits).

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset. Sampled on the CLK rising edge and applied regardless of EN.
- EN  in  1  advance enable. When 0, every register, counter and FSM state holds.
- SEL  in  1  requested mode: 1 = short, 0 = long. Sampled only on EN=1 edges.
- D  in  WIDTH  input sample. Captured on every EN=1 edge.
- Q  out  WIDTH  registered output.
- Q_VLD  out  1  Q holds a real sample.
- MODE  out  1  effective mode: 1 = short; 0 = long or switching to long.
- BUSY  out  1  high while in SW_L.
- DROP  out  1  one-cycle pulse: in-flight samples were discarded.

Behaviour:
- Reset (RST_N=0 at an edge):
  - Q = RST_VAL; stage[0..DEPTH-1] = RST_VAL.
  - Q_VLD = 0, DROP = 0, hold_cnt = 0.
  - State = SHORT, so MODE = 1, BUSY = 0.
  - Reset mid-operation fully aborts any switch.
- Delay line:
  - On every EN=1 edge, in every state: stage[0] <= D, stage[i] <= stage[i-1].
  - tail = stage[DEPTH-1] value before the shift, i.e. D from DEPTH EN-edges earlier.
- DROP: defaults to 0 on every edge; asserted for exactly one cycle only where stated below.
- States: SHORT, SW_L, LONG. Transitions only occur on EN=1 edges.
- SHORT, SEL=1:
  - Q <= D; Q_VLD <= 1.
- SHORT, SEL=0:
  - Q holds; state -> SW_L; hold_cnt <= 1.
  - BUSY = 1, MODE = 0.
- SW_L, SEL=0:
  - Q holds.
  - If hold_cnt == DEPTH, state -> LONG and hold_cnt <= 0; otherwise hold_cnt increments.
  - This gives exactly DEPTH hold edges in total. The first LONG output is the sample immediately following the last SHORT output.
- SW_L, SEL=1 (abort):
  - Q <= D; state -> SHORT; DROP = 1.
  - The samples skipped during the hold are lost.
- LONG, SEL=0:
  - Q <= tail; Q_VLD <= 1.
  - Latency: D captured at EN-edge x appears on Q after EN-edge x+DEPTH.
- LONG, SEL=1:
  - Q <= D; state -> SHORT; DROP = 1.
  - The DEPTH in-flight samples are discarded.
- Startup in long mode:
  - From reset with SEL=0, the SW_L hold keeps Q_VLD=0.
  - The first valid Q is D(first EN edge), produced DEPTH+1 EN-edges later.
- EN=0 during SW_L: hold_cnt freezes; SEL changes are ignored until the next EN=1 edge.
- Derived outputs:
  - BUSY = (state == SW_L).
  - MODE = (state == SHORT).
- Outputs carry no combinational path from D; Q and DROP are registered.

Test Plan:
(All tests: WIDTH=8, DEPTH=4, EN=1, D = edge index 1,2,3,... unless stated.)
- Reset with SEL=1, release, then 10 edges -> Q follows D with 1-cycle latency, Q_VLD=1 after the first edge, MODE=1, BUSY=0, DROP never set.
- Reset with SEL=0 -> BUSY=1 for edges 1-4 with Q=RST_VAL and Q_VLD=0. After edge 5: Q=1, Q_VLD=1, MODE=0. Q then increments by 1 per edge.
- SHORT showing Q=20, SEL falls before edge 21 -> Q holds 20 through edges 21-24. After edge 25, Q=21 and then increments with no gap or repeat. DROP stays 0.
- LONG with Q=30, SEL rises before the next edge (D=35) -> Q=35, DROP=1 for one cycle, MODE=1. Samples 31-34 are never output.
- SW_L abort: SEL=0 for 2 edges then SEL=1 -> Q jumps to the current D, DROP pulses once, state returns to SHORT.
- EN toggling 1/0 during SW_L, plus RST_N=0 for one edge mid-switch -> holds count only EN=1 edges. Reset returns Q=RST_VAL, Q_VLD=0, BUSY=0 on the next edge.
